// File: rtl/sram_controller_if.sv
// sram_controller_if: pipeline-side load/store handshake of sram_controller.
// addr_err exists only when SRAM_CTRL_ADDR_CHECK_EN is defined.
interface sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
`ifdef SRAM_CTRL_ADDR_CHECK_EN
  logic        addr_err;
  modport master (output wr_en, rd_en, address, write_data, input read_data, ready, addr_err);
  modport slave (input wr_en, rd_en, address, write_data, output read_data, ready, addr_err);
`else
  modport master (output wr_en, rd_en, address, write_data, input read_data, ready);
  modport slave (input wr_en, rd_en, address, write_data, output read_data, ready);
`endif
endinterface

// File: rtl/sram_controller.sv
// sram_controller: splits 32-bit loads/stores into two 16-bit async SRAM accesses, low half first.
// Define SRAM_CTRL_ADDR_CHECK_EN to reject out-of-range/misaligned addresses via addr_err.
module sram_controller #(
  parameter int BASE_ADDR     = 1024,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  sram_controller_if.slave bus,
  output logic [17:0]      SRAM_ADDR,
  output logic             SRAM_WE_N,
  inout  wire  [15:0]      SRAM_DQ
);
  localparam int CW = ACCESS_CYCLES > 1 ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic          op_wr;
  logic [16:0]   widx;
  logic [31:0]   wdata;
  logic [15:0]   lo;
  logic [31:0]   rdata;
  logic [31:0]   off;
  logic          req;
  logic          err;
  assign req = bus.wr_en | bus.rd_en;
  assign off = bus.address - 32'(BASE_ADDR);
`ifdef SRAM_CTRL_ADDR_CHECK_EN
  logic addr_err;
  assign err = (bus.address < 32'(BASE_ADDR)) | (|bus.address[1:0]) | (|(off >> 19));
  assign bus.addr_err = addr_err;
  always_ff @(posedge clk or posedge rst)
    if (rst) addr_err <= 1'b0;
    else addr_err <= state == IDLE && req && err;
`else
  assign err = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      op_wr <= 1'b0;
      widx  <= '0;
      wdata <= '0;
      lo    <= '0;
      rdata <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          op_wr <= bus.wr_en;
          widx  <= 17'(off >> 2);
          wdata <= bus.write_data;
          cnt   <= '0;
          state <= err ? DONE : LOW;
        end
        LOW: if (cnt == LAST) begin
          cnt   <= '0;
          state <= HIGH;
          if (!op_wr) lo <= SRAM_DQ;
        end else cnt <= cnt + 1'b1;
        HIGH: if (cnt == LAST) begin
          cnt   <= '0;
          state <= DONE;
          if (!op_wr) rdata <= {SRAM_DQ, lo};
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  // SRAM pins decode from registered state, so reset forces them idle at once
  assign SRAM_ADDR     = state == LOW ? {widx, 1'b0} : state == HIGH ? {widx, 1'b1} : '0;
  assign SRAM_WE_N     = !(op_wr && (state == LOW || state == HIGH));
  assign SRAM_DQ       = SRAM_WE_N ? 16'hzzzz : state == LOW ? wdata[15:0] : wdata[31:16];
  assign bus.read_data = rdata;
  assign bus.ready     = state == DONE || (state == IDLE && !req);
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed loads/stores against a behavioural async SRAM with a read-result scoreboard.
module tb_sram_controller;
  localparam int AC   = 2;
  localparam int BUSY = 1 + 2 * AC;
  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic park = 1'b1;
  always #10 clk = ~clk;
  sram_controller_if bus ();
  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N;
  wire  [15:0] SRAM_DQ;
  sram_controller #(.BASE_ADDR(1024), .ACCESS_CYCLES(AC)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N), .SRAM_DQ(SRAM_DQ)
  );
  logic [15:0] mem [0:63] = '{default: 16'h0};
  wire  [15:0] rd_word = mem[SRAM_ADDR[5:0]];
  wire  [15:0] sram_q;
  assign #12 sram_q = rd_word;
  // park drives a fixed pattern so an errant controller driver shows up on the bus
  assign SRAM_DQ = park ? 16'h5A5A : SRAM_WE_N ? sram_q : 16'hzzzz;
  always @(negedge clk) if (!SRAM_WE_N) mem[SRAM_ADDR[5:0]] = SRAM_DQ;
  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] exp_q [$];
  logic [31:0] ref_words [0:31] = '{default: 32'h0};
  logic [31:0] last_rd = 32'h0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                        input logic err, input string tag);
    int          lowc = 0;
    int          wec  = 0;
    int          bad  = 0;
    logic        done = 1'b0;
    logic [31:0] idx  = ((a - 32'd1024) >> 2) & 32'd31;
    logic [31:0] exp;
    @(negedge clk);
    bus.wr_en = w; bus.rd_en = r; bus.address = a; bus.write_data = d;
    if (w && !err) ref_words[idx[4:0]] = d;
    else if (r && !err) exp_q.push_back(ref_words[idx[4:0]]);
    #1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.ready) done = 1'b1; else lowc++;
      if (!SRAM_WE_N) wec++;
      else if (SRAM_DQ !== sram_q) bad++;
      if (!done) begin
        @(negedge clk);
        if (i == 0) begin
          bus.wr_en = 1'b0; bus.rd_en = 1'b0;
          bus.address = $urandom; bus.write_data = $urandom;
        end
        #1;
      end
    end
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " busy"}, 32'(lowc), err ? 32'd1 : 32'(BUSY));
    check({tag, " we_n"}, 32'(wec), (w && !err) ? 32'(2 * AC) : 32'd0);
    check({tag, " dq"}, 32'(bad), 32'd0);
    if (r && !w && !err) begin
      exp = exp_q.size() > 0 ? exp_q.pop_front() : 32'hxxxxxxxx;
      last_rd = exp;
    end
    check({tag, " rdata"}, bus.read_data, last_rd);
`ifdef SRAM_CTRL_ADDR_CHECK_EN
    check({tag, " addr_err"}, 32'(bus.addr_err), 32'(err));
`endif
  endtask
  initial begin
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.address = '0; bus.write_data = '0;
    #5;
    check("rst ready", 32'(bus.ready), 32'd1);
    check("rst rdata", bus.read_data, 32'h0);
    check("rst we_n", 32'(SRAM_WE_N), 32'd1);
    check("rst addr", 32'(SRAM_ADDR), 32'h0);
    check("rst dq", 32'(SRAM_DQ), 32'h5A5A);
    @(negedge clk);
    rst = 1'b0; park = 1'b0;
    access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0, "st1024");
    check("word0", 32'(mem[0]), 32'hBEEF);
    check("word1", 32'(mem[1]), 32'hDEAD);
    access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, "ld1024");
    access(1'b1, 1'b0, 32'd1028, 32'h12345678, 1'b0, "st1028");
    check("word2", 32'(mem[2]), 32'h5678);
    check("word3", 32'(mem[3]), 32'h1234);
    access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0, "ld1028");
    access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, "ld1024b");
    access(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 1'b0, "wr+rd");
    check("word4", 32'(mem[4]), 32'hF00D);
    check("word5", 32'(mem[5]), 32'hCAFE);
`ifdef SRAM_CTRL_ADDR_CHECK_EN
    access(1'b0, 1'b1, 32'd1030, 32'h0, 1'b1, "misalign");
    access(1'b0, 1'b1, 32'd1000, 32'h0, 1'b1, "below");
`else
    access(1'b0, 1'b1, 32'd1030, 32'h0, 1'b0, "misalign");
`endif
    @(negedge clk);
    bus.wr_en = 1'b1; bus.address = 32'd1028; bus.write_data = 32'hAAAA5555;
    @(posedge clk);
    @(negedge clk);
    bus.wr_en = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("high addr", 32'(SRAM_ADDR), 32'd3);
    rst = 1'b1; park = 1'b1;
    #1;
    check("mid rst we_n", 32'(SRAM_WE_N), 32'd1);
    check("mid rst addr", 32'(SRAM_ADDR), 32'h0);
    check("mid rst ready", 32'(bus.ready), 32'd1);
    check("mid rst rdata", bus.read_data, 32'h0);
    check("mid rst dq", 32'(SRAM_DQ), 32'h5A5A);
    check("partial word2", 32'(mem[2]), 32'h5555);
    check("partial word3", 32'(mem[3]), 32'h1234);
    @(negedge clk);
    rst = 1'b0; park = 1'b0;
    last_rd = 32'h0;
    ref_words[1] = 32'h12345555;
    access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0, "ld partial");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
